// File: rtl/mem_word_sequencer.sv
// Word-to-byte RAM sequencer: one 32-bit big-endian load/store as four byte accesses.
// Optional MISALIGN_TRAP_EN: misaligned requests complete at once with rsp_err.
module mem_word_sequencer #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          wr_q, wr_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic [23:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          accept;
  logic          misalign;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW];
  assign accept = req_valid & (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = misalign ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 2'd3) begin
          state_d = wr_q ? DONE : DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so byte k lands at cnt k+1.
  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    wr_d    = wr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d = req_addr[AW-1:0];
          wr_d   = req_write;
          wbuf_d = req_wdata;
          cnt_d  = 2'd0;
          err_d  = misalign;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q != 2'd0) begin
          rbuf_d = {rbuf_q[15:0], ram_rdata};
        end
      end
      DRAIN: begin
        rdata_d = {rbuf_q, ram_rdata};
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    rsp_rdata = rdata_q;
    ram_we    = (state_q == ISSUE) & wr_q;
    ram_addr  = base_q;
    if (state_q == ISSUE) begin
      ram_addr = base_q + AW'(cnt_q);
    end
    unique case (cnt_q)
      2'd0:    ram_wdata = wbuf_q[31:24];
      2'd1:    ram_wdata = wbuf_q[23:16];
      2'd2:    ram_wdata = wbuf_q[15:8];
      default: ram_wdata = wbuf_q[7:0];
    endcase
`ifdef MISALIGN_TRAP_EN
    rsp_err = (state_q == DONE) & err_q;
`else
    rsp_err = 1'b0 & err_q;
`endif
  end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Scoreboard bench for mem_word_sequencer with a registered byte RAM model.
// Build with MISALIGN_TRAP_EN to exercise the trap path.
module tb_mem_word_sequencer;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  mem_word_sequencer #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    ncyc++;
    if (rst_n) begin
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("rsp_cycle", ncyc, r.cyc);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) begin
          chk("we_unexpected", {16'd0, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", ncyc, w.cyc);
          chk("wr_addr", {16'd0, ram_addr}, {16'd0, w.a});
          chk("wr_data", {24'd0, ram_wdata}, {24'd0, w.d});
        end
      end
    end
  end

  // lat: response cycle after accept; nwr: RAM writes expected
  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int lat,
                       input logic [31:0] erd, input logic eerr,
                       input int nwr, input bit keep,
                       output int acc);
    int n;
    logic [31:0] sh;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    acc = ncyc;
    if (lat > 0) rq.push_back('{acc + lat, erd, eerr});
    sh = d;
    for (int i = 0; i < nwr; i++) begin
      wq.push_back('{acc + 1 + i, a[15:0] + 16'(i), sh[31:24]});
      sh = sh << 8;
    end
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  int acc, acc2, n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, ram_wdata}, 32'd0);
    rst_n = 1'b1;

    // T1, T2
    issue(1, 32'h0010, 32'hDEADBEEF, 5, 32'h0, 0, 4, 0, acc);
    issue(0, 32'h0010, 32'h0, 6, 32'hDEADBEEF, 0, 0, 0, acc);
    // T3
    issue(1, 32'h0000_FFFE, 32'h01020304, 5, 32'hDEADBEEF, 0, 4, 0, acc);
    issue(0, 32'h0000_FFFE, 32'h0, 6, 32'h01020304, 0, 0, 0, acc);

    // T4: reset lands right after the second write
    issue(1, 32'h0020, 32'hAABBCCDD, 0, 32'h0, 0, 2, 0, acc);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_we", {31'd0, ram_we}, 32'd0);
    chk("t4_ready", {31'd0, req_ready}, 32'd1);
    chk("t4_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t4_m20", {24'd0, mem[16'h20]}, 32'hAA);
    chk("t4_m21", {24'd0, mem[16'h21]}, 32'hBB);
    chk("t4_m22", {24'd0, mem[16'h22]}, 32'h00);
    chk("t4_m23", {24'd0, mem[16'h23]}, 32'h00);
    chk("t4_rdata", rsp_rdata, 32'd0);

    // T5: held valid, address changed mid-access
    issue(0, 32'h0010, 32'h0, 6, 32'hDEADBEEF, 0, 0, 1, acc);
    issue(0, 32'h2000, 32'h0, 6, 32'h0, 0, 0, 0, acc2);
    chk("t5_accept_gap", acc2 - acc, 32'd7);

    // T6
`ifdef MISALIGN_TRAP_EN
    issue(1, 32'h0013, 32'h11223344, 1, 32'h0, 1, 0, 0, acc);
`else
    issue(1, 32'h0013, 32'h11223344, 5, 32'h0, 0, 4, 0, acc);
    issue(0, 32'h0013, 32'h0, 6, 32'h11223344, 0, 0, 0, acc);
`endif

    n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", rq.size(), 32'd0);
    chk("wr_queue_empty", wq.size(), 32'd0);
    chk("idle_addr", {16'd0, ram_addr}, 32'h13);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
